// File: rtl/adc_frame_sequencer.sv
// adc_frame_sequencer
// Paces the ADC SPI reader with periodic one-cycle sample strobes, captures each returned
// word on the rising edge of its data-valid, and assembles N_POINTS samples into a frame
// that is handed to the FFT stage through a valid/ack handshake and a registered read port.
//
// Build option: define ADC_SEQ_PINGPONG_EN for two banks. In that build writing continues
// into the other bank while a frame is presented. The default build has a single bank and
// pauses sampling while a frame is presented.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   enable_i       run sampling
//   clr_status_i   one-cycle pulse clearing overrun_o and timeout_o
//   adc_sample_o   one-cycle conversion strobe to the ADC SPI block
//   adc_dv_i       ADC SPI data valid
//   adc_data_i     ADC SPI data word
//   frame_valid_o  complete frame available on the read port
//   frame_ack_i    consumer releases the presented frame
//   rd_addr_i      read index into the presented frame
//   rd_data_o      registered read data (1 clock latency)
//   wr_idx_o       next write position in the frame being filled
//   overrun_o      sticky: a tick or a completed frame was lost
//   timeout_o      sticky: data valid did not arrive within DV_TIMEOUT clocks
module adc_frame_sequencer #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned N_POINTS      = 32,
  parameter int unsigned ADDR_W        = 5,
  parameter int unsigned SAMPLE_PERIOD = 64,
  parameter int unsigned DV_TIMEOUT    = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              clr_status_i,
  output logic              adc_sample_o,
  input  logic              adc_dv_i,
  input  logic [DATA_W-1:0] adc_data_i,
  output logic              frame_valid_o,
  input  logic              frame_ack_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W-1:0] wr_idx_o,
  output logic              overrun_o,
  output logic              timeout_o
);

  localparam int unsigned PerW = $clog2(SAMPLE_PERIOD + 1);
  localparam int unsigned ToW  = $clog2(DV_TIMEOUT + 1);
  localparam logic [PerW-1:0]   PerReload = PerW'(SAMPLE_PERIOD - 1);
  localparam logic [ToW-1:0]    ToLast    = ToW'(DV_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] IdxLast   = ADDR_W'(N_POINTS - 1);

  typedef enum logic [1:0] {StIdle, StTrigger, StWaitDv, StStore} state_e;

  state_e            state_q;
  logic [PerW-1:0]   per_cnt_q;
  logic              tick_q;
  logic [ToW-1:0]    to_cnt_q;
  logic              dv_q, dv_prev_q;
  logic              adc_sample_q;
  logic              frame_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] wr_idx_q;
  logic              overrun_q, timeout_q;
  logic              dv_rise;
  logic              bank_avail;

  assign dv_rise = dv_q & ~dv_prev_q;

`ifdef ADC_SEQ_PINGPONG_EN
  logic              wr_bank_q;
  logic [ADDR_W:0]   wr_addr, rd_mem_addr;
  logic [DATA_W-1:0] mem_q [2*N_POINTS];
  assign wr_addr     = {wr_bank_q, wr_idx_q};
  // The presented frame always lives in the bank not being written.
  assign rd_mem_addr = {~wr_bank_q, rd_addr_i};
  assign bank_avail  = 1'b1;
`else
  logic [ADDR_W-1:0] wr_addr, rd_mem_addr;
  logic [DATA_W-1:0] mem_q [N_POINTS];
  assign wr_addr     = wr_idx_q;
  assign rd_mem_addr = rd_addr_i;
  assign bank_avail  = ~frame_valid_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == StStore) begin
      mem_q[wr_addr] <= adc_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      per_cnt_q     <= PerReload;
      tick_q        <= 1'b0;
      to_cnt_q      <= '0;
      dv_q          <= 1'b0;
      dv_prev_q     <= 1'b0;
      adc_sample_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      rd_data_q     <= '0;
      wr_idx_q      <= '0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef ADC_SEQ_PINGPONG_EN
      wr_bank_q     <= 1'b0;
`endif
    end else begin
      adc_sample_q <= 1'b0;
      dv_q         <= adc_dv_i;
      dv_prev_q    <= dv_q;
      rd_data_q    <= mem_q[rd_mem_addr];

      // Period counter; the tick is registered so the first strobe lands SAMPLE_PERIOD+1
      // clocks after enable rises, letting any conversion in the unreset ADC finish.
      if (!enable_i) begin
        per_cnt_q <= PerReload;
        tick_q    <= 1'b0;
      end else if (per_cnt_q == '0) begin
        per_cnt_q <= PerReload;
        tick_q    <= 1'b1;
      end else begin
        per_cnt_q <= per_cnt_q - PerW'(1);
        tick_q    <= 1'b0;
      end

      // Clears first so that a status event later in this block wins.
      if (clr_status_i) begin
        overrun_q <= 1'b0;
        timeout_q <= 1'b0;
      end

      if (frame_ack_i && frame_valid_q) begin
        frame_valid_q <= 1'b0;
      end

      if (tick_q && state_q != StIdle) begin
        overrun_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (!enable_i) begin
            wr_idx_q <= '0;
          end else if (tick_q && bank_avail) begin
            adc_sample_q <= 1'b1;
            state_q      <= StTrigger;
          end
        end
        StTrigger: begin
          to_cnt_q <= '0;
          state_q  <= StWaitDv;
        end
        StWaitDv: begin
          if (dv_rise) begin
            state_q <= StStore;
          end else if (to_cnt_q == ToLast) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
          end
        end
        StStore: begin
          wr_idx_q <= wr_idx_q + ADDR_W'(1);
          state_q  <= StIdle;
          if (wr_idx_q == IdxLast) begin
`ifdef ADC_SEQ_PINGPONG_EN
            // An ack in this same cycle frees the presented bank in time for the swap.
            if (!frame_valid_q || frame_ack_i) begin
              wr_bank_q     <= ~wr_bank_q;
              frame_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
`else
            frame_valid_q <= 1'b1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign adc_sample_o  = adc_sample_q;
  assign frame_valid_o = frame_valid_q;
  assign rd_data_o     = rd_data_q;
  assign wr_idx_o      = wr_idx_q;
  assign overrun_o     = overrun_q;
  assign timeout_o     = timeout_q;

endmodule
